// File: rtl/port_power_seq_pkg.sv
// Shared types and constants for the LED power sequencer.
package port_power_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF        = 3'd0,
    ST_WAIT_PWRGD = 3'd1,
    ST_STAGGER    = 3'd2,
    ST_ON         = 3'd3,
    ST_FAULT      = 3'd4
  } state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/port_power_seq_sync.sv
// Two-flop synchroniser for a single asynchronous level; output is 0 during reset.
module sync_bit (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/port_power_seq.sv
// LED power sequencer: supply enable, power-good wait, staggered port enables, fault latch.
// Optional pwrgd loss glitch filter: define PORT_POWER_SEQ_PWRGD_FILTER_EN.
module port_power_seq
  import port_power_seq_pkg::*;
#(
  parameter int unsigned PORT_COUNT           = 8,
  parameter int unsigned STAGGER_CYCLES       = 1000000,
  parameter int unsigned PWRGD_TIMEOUT_CYCLES = 5000000,
  parameter int unsigned COOLDOWN_CYCLES      = 10000000,
  parameter int unsigned FILTER_CYCLES        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  enable_i,
  input  logic                  pwrgd_i,
  input  logic                  fault_clear_i,
  output logic                  pwr_en_o,
  output logic [PORT_COUNT-1:0] port_en_o,
  output logic                  ready_o,
  output logic                  fault_o,
  output logic [STATE_W-1:0]    state_o
);

  localparam int unsigned WAIT_W = cnt_width(PWRGD_TIMEOUT_CYCLES - 1);
  localparam int unsigned STAG_W = cnt_width(STAGGER_CYCLES - 1);
  localparam int unsigned COOL_W = cnt_width(COOLDOWN_CYCLES);

  localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(PWRGD_TIMEOUT_CYCLES - 1);
  localparam logic [STAG_W-1:0]     STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
  localparam logic [COOL_W-1:0]     COOL_SAT  = COOL_W'(COOLDOWN_CYCLES);
  localparam logic [PORT_COUNT-1:0] PORT_ONE  = PORT_COUNT'(1);

  if (STAGGER_CYCLES < 1 || FILTER_CYCLES < 1) begin : g_bad_param
    $error("port_power_seq: STAGGER_CYCLES and FILTER_CYCLES must be at least 1");
  end

  state_e                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [STAG_W-1:0]       stag_cnt_q, stag_cnt_d;
  logic [COOL_W-1:0]       cool_cnt_q, cool_cnt_d;
  logic                    pwr_en_q, pwr_en_d;
  logic [PORT_COUNT-1:0]   port_en_q, port_en_d;
  logic                    ready_q, ready_d;
  logic                    fault_q, fault_d;

  logic                    pwrgd_s;
  logic                    pwrgd_lost;
  logic                    stag_hit;
  logic                    stay;
  logic [PORT_COUNT-1:0]   port_shift;

  sync_bit u_pwrgd_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pwrgd_i),
    .q_o     (pwrgd_s)
  );

`ifdef PORT_POWER_SEQ_PWRGD_FILTER_EN
  localparam int unsigned         FILT_W    = cnt_width(FILTER_CYCLES - 1);
  localparam logic [FILT_W-1:0]   FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;

  // Counts consecutive low samples; the final low sample itself declares the loss.
  assign pwrgd_lost = !pwrgd_s && (filt_cnt_q == FILT_LAST);

  always_comb begin
    filt_cnt_d = '0;
    if (stay && (state_q == ST_STAGGER || state_q == ST_ON) && !pwrgd_s)
      filt_cnt_d = filt_cnt_q + FILT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) filt_cnt_q <= '0;
    else          filt_cnt_q <= filt_cnt_d;
  end
`else
  assign pwrgd_lost = !pwrgd_s;
`endif

  assign stag_hit   = (stag_cnt_q == STAG_LAST);
  assign port_shift = (port_en_q << 1) | PORT_ONE;
  assign stay       = (state_d == state_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_OFF;
      wait_cnt_q <= '0;
      stag_cnt_q <= '0;
      cool_cnt_q <= '0;
      pwr_en_q   <= 1'b0;
      port_en_q  <= '0;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stag_cnt_q <= stag_cnt_d;
      cool_cnt_q <= cool_cnt_d;
      pwr_en_q   <= pwr_en_d;
      port_en_q  <= port_en_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF: begin
        if (enable_i) state_d = ST_WAIT_PWRGD;
      end
      ST_WAIT_PWRGD: begin
        if (!enable_i)                state_d = ST_OFF;
        else if (pwrgd_s)             state_d = (PORT_COUNT == 1) ? ST_ON : ST_STAGGER;
        else if (wait_cnt_q == WAIT_LAST) state_d = ST_FAULT;
      end
      ST_STAGGER: begin
        if (!enable_i)                     state_d = ST_OFF;
        else if (pwrgd_lost)               state_d = ST_FAULT;
        else if (stag_hit && &port_shift)  state_d = ST_ON;
      end
      ST_ON: begin
        if (!enable_i)       state_d = ST_OFF;
        else if (pwrgd_lost) state_d = ST_FAULT;
      end
      ST_FAULT: begin
        if (fault_clear_i && !enable_i && cool_cnt_q == COOL_SAT) state_d = ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase

    // Every counter restarts from zero on any state change.
    wait_cnt_d = '0;
    stag_cnt_d = '0;
    cool_cnt_d = '0;
    if (stay && state_q == ST_WAIT_PWRGD)
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    if (stay && state_q == ST_STAGGER && !stag_hit)
      stag_cnt_d = stag_cnt_q + STAG_W'(1);
    if (stay && state_q == ST_FAULT)
      cool_cnt_d = (cool_cnt_q == COOL_SAT) ? cool_cnt_q : cool_cnt_q + COOL_W'(1);
  end

  always_comb begin
    pwr_en_d  = (state_d == ST_WAIT_PWRGD) || (state_d == ST_STAGGER) || (state_d == ST_ON);
    ready_d   = (state_q == ST_ON) && (state_d == ST_ON);
    fault_d   = (state_d == ST_FAULT);
    port_en_d = port_en_q;
    if (state_d == ST_OFF || state_d == ST_FAULT)
      port_en_d = '0;
    else if (state_q == ST_WAIT_PWRGD && state_d != ST_WAIT_PWRGD)
      port_en_d = PORT_ONE;
    else if (state_q == ST_STAGGER && stag_hit)
      port_en_d = port_shift;
  end

  assign pwr_en_o  = pwr_en_q;
  assign port_en_o = port_en_q;
  assign ready_o   = ready_q;
  assign fault_o   = fault_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_port_power_seq.sv
// Directed bench for port_power_seq: vector table plus hand-written corner sequences.
module tb_port_power_seq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pg;
  logic       clr;
  logic       pwr_en;
  logic [3:0] port_en;
  logic       ready;
  logic       fault;
  logic [2:0] state;

  int unsigned n_pass;
  int unsigned n_total;

  typedef struct {
    string       name;
    int unsigned n;
    logic        en;
    logic        pg;
    logic        clr;
    logic        pwr;
    logic [3:0]  port;
    logic        rdy;
    logic        flt;
    logic [2:0]  st;
  } vec_t;

  vec_t vecs[$];

  port_power_seq #(
    .PORT_COUNT           (4),
    .STAGGER_CYCLES       (10),
    .PWRGD_TIMEOUT_CYCLES (50),
    .COOLDOWN_CYCLES      (20),
    .FILTER_CYCLES        (16)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .enable_i      (en),
    .pwrgd_i       (pg),
    .fault_clear_i (clr),
    .pwr_en_o      (pwr_en),
    .port_en_o     (port_en),
    .ready_o       (ready),
    .fault_o       (fault),
    .state_o       (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    else             n_pass++;
  endtask

  task automatic chk_all(input string name, input logic p, input logic [3:0] port,
                         input logic r, input logic f, input logic [2:0] s);
    chk({name, ".pwr_en"},  32'(pwr_en),  32'(p));
    chk({name, ".port_en"}, 32'(port_en), 32'(port));
    chk({name, ".ready"},   32'(ready),   32'(r));
    chk({name, ".fault"},   32'(fault),   32'(f));
    chk({name, ".state"},   32'(state),   32'(s));
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void add(input string name, input int unsigned n, input logic e,
                              input logic g, input logic c, input logic p,
                              input logic [3:0] port, input logic r, input logic f,
                              input logic [2:0] s);
    vec_t v;
    v.name = name; v.n = n; v.en = e; v.pg = g; v.clr = c;
    v.pwr = p; v.port = port; v.rdy = r; v.flt = f; v.st = s;
    vecs.push_back(v);
  endfunction

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    en      = 1'b0;
    pg      = 1'b0;
    clr     = 1'b0;

    // Nominal bring-up: cycle k means just after rising edge k following reset release.
    add("wait_enter", 1,  1, 0, 0, 1, 4'h0, 0, 0, 3'd1);
    add("wait_hold",  4,  1, 0, 0, 1, 4'h0, 0, 0, 3'd1);
    add("sync_lag",   2,  1, 1, 0, 1, 4'h0, 0, 0, 3'd1);
    add("port0",      1,  1, 1, 0, 1, 4'h1, 0, 0, 3'd2);
    add("port0_hold", 9,  1, 1, 0, 1, 4'h1, 0, 0, 3'd2);
    add("port1",      1,  1, 1, 0, 1, 4'h3, 0, 0, 3'd2);
    add("port2",      10, 1, 1, 0, 1, 4'h7, 0, 0, 3'd2);
    add("port3_on",   10, 1, 1, 0, 1, 4'hF, 0, 0, 3'd3);
    add("ready",      1,  1, 1, 0, 1, 4'hF, 1, 0, 3'd3);
    add("glitch_lo",  1,  1, 0, 0, 1, 4'hF, 1, 0, 3'd3);
    add("glitch_sync",1,  1, 1, 0, 1, 4'hF, 1, 0, 3'd3);
`ifdef PORT_POWER_SEQ_PWRGD_FILTER_EN
    add("glitch_ign", 1,  1, 1, 0, 1, 4'hF, 1, 0, 3'd3);
    add("low_15",     17, 1, 0, 0, 1, 4'hF, 1, 0, 3'd3);
    add("low_16",     1,  1, 0, 0, 0, 4'h0, 0, 1, 3'd4);
`else
    add("loss_fault", 1,  1, 1, 0, 0, 4'h0, 0, 1, 3'd4);
`endif
    // Fault clear gating, counted from FAULT entry.
    add("clr_pre",    5,  1, 1, 0, 0, 4'h0, 0, 1, 3'd4);
    add("clr_early",  1,  1, 1, 1, 0, 4'h0, 0, 1, 3'd4);
    add("cool_run",   13, 1, 1, 0, 0, 4'h0, 0, 1, 3'd4);
    add("clr_unsat",  1,  0, 1, 1, 0, 4'h0, 0, 1, 3'd4);
    add("clr_en_hi",  1,  1, 1, 1, 0, 4'h0, 0, 1, 3'd4);
    add("clr_ok",     1,  0, 1, 1, 0, 4'h0, 0, 0, 3'd0);
    // Power-good timeout.
    add("off_settle", 3,  0, 0, 0, 0, 4'h0, 0, 0, 3'd0);
    add("to_wait",    1,  1, 0, 0, 1, 4'h0, 0, 0, 3'd1);
    add("to_hold",    48, 1, 0, 0, 1, 4'h0, 0, 0, 3'd1);
    add("to_edge",    1,  1, 0, 0, 1, 4'h0, 0, 0, 3'd1);
    add("to_fault",   1,  1, 0, 0, 0, 4'h0, 0, 1, 3'd4);
    add("to_en_lo",   2,  0, 0, 0, 0, 4'h0, 0, 1, 3'd4);
    add("to_en_hi",   2,  1, 0, 0, 0, 4'h0, 0, 1, 3'd4);

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_hold", 0, 4'h0, 0, 0, 3'd0);
    #1 rst_n = 1'b1;
    step(1);
    chk_all("reset_rel", 0, 4'h0, 0, 0, 3'd0);

    foreach (vecs[i]) begin
      en  = vecs[i].en;
      pg  = vecs[i].pg;
      clr = vecs[i].clr;
      step(vecs[i].n);
      chk_all(vecs[i].name, vecs[i].pwr, vecs[i].port, vecs[i].rdy, vecs[i].flt, vecs[i].st);
    end
    clr = 1'b0;

    // Reset out of FAULT.
    en = 1'b0; pg = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all("rst_from_fault", 0, 4'h0, 0, 0, 3'd0);
    @(negedge clk) rst_n = 1'b1;
    step(1);

    // pwrgd_s rises on the very cycle the timeout would fire: pwrgd wins.
    en = 1'b1;
    step(1);
    step(46);
    chk_all("race_wait", 1, 4'h0, 0, 0, 3'd1);
    step(1);
    pg = 1'b1;
    step(2);
    chk_all("race_last", 1, 4'h0, 0, 0, 3'd1);
    step(1);
    chk_all("race_win", 1, 4'h1, 0, 0, 3'd2);

    // Disable mid-stagger drops everything at once, no fault.
    step(10);
    chk_all("mid_stag", 1, 4'h3, 0, 0, 3'd2);
    en = 1'b0;
    step(1);
    chk_all("dis_stag", 0, 4'h0, 0, 0, 3'd0);

    // Asynchronous reset while ON.
    en = 1'b1;
    step(2);
    chk_all("fast_stag", 1, 4'h1, 0, 0, 3'd2);
    step(31);
    chk_all("on_again", 1, 4'hF, 1, 0, 3'd3);
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 4'h0, 0, 0, 3'd0);
    en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step(2);
    chk_all("after_rst", 0, 4'h0, 0, 0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
